// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 16;

    // High phase length of a period of n cycles
    function automatic logic [31:0] half_period(input logic [31:0] n);
        return n >> 1;
    endfunction

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: active/shadow divisor, counter and registered outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             en,
    input  logic             sync,
    output logic             clkout,
    output logic             tick,
    output logic             pending
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_q, shadow_q, cnt_q;
    logic [DIV_W-1:0] div_d, shadow_d, cnt_d;
    logic             run_q, run_d, pend_d, boundary, clk_d, tick_d;
    logic [31:0]      h;

    always_comb begin
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pending;
        cnt_d    = '0;
        run_d    = 1'b0;
        boundary = 1'b0;
        if (run_q) begin
            boundary = sync || (cnt_q == div_q - ONE);
            if (!en) begin
                if (wr_en)        div_d = wr_div;
                else if (pending) div_d = shadow_q;
                pend_d = 1'b0;
            end else if (boundary) begin
                if (pending) div_d = shadow_q;
                pend_d = 1'b0;
                // A write landing on the boundary waits for the next one
                if (wr_en) begin
                    shadow_d = wr_div;
                    pend_d   = 1'b1;
                end
                run_d = (div_d != '0);
            end else begin
                cnt_d = cnt_q + ONE;
                run_d = 1'b1;
                if (wr_en) begin
                    shadow_d = wr_div;
                    pend_d   = 1'b1;
                end
            end
        end else begin
            // Halted: writes (or a shadow stranded by a divide-by-0 halt) load directly
            if (wr_en)        div_d = wr_div;
            else if (pending) div_d = shadow_q;
            pend_d = 1'b0;
            run_d  = en && (div_d != '0);
        end
        h      = half_period(32'(div_d));
        clk_d  = run_d && (32'(cnt_d) < h);
        tick_d = run_d && (cnt_d == div_d - ONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= DIV_W'(RESET_DIV);
            shadow_q <= DIV_W'(RESET_DIV);
            pending  <= 1'b0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            clkout   <= 1'b0;
            tick     <= 1'b0;
        end else begin
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pending  <= pend_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            clkout   <= clk_d;
            tick     <= tick_d;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with shared config bus and sync.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = 2,
    localparam int CH_W     = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    // Only indices below NUM_CH are decoded, so out-of-range writes are dropped
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (sel),
            .wr_div  (cfg_div),
            .en      (ch_en[i]),
            .sync    (sync),
            .clkout  (clkout[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: vector table plus multi-cycle sequences.
module tb_prog_clk_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic [2:0] ch_en = '0;
    logic       sync = 1'b0;
    logic [2:0] clkout, tick, pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prog_clk_divider #(.NUM_CH(3), .DIV_W(8), .RESET_DIV(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .ch_en   (ch_en),
        .sync    (sync),
        .clkout  (clkout),
        .tick    (tick),
        .pending (pending)
    );

    typedef struct {
        logic       r;
        logic [2:0] en;
        logic       we;
        logic [1:0] ch;
        logic [7:0] dv;
        logic       sy;
        logic [2:0] ec, et, ep;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] en, input logic we,
                       input logic [1:0] ch, input logic [7:0] dv, input logic sy,
                       input logic [2:0] ec, input logic [2:0] et, input logic [2:0] ep,
                       input string nm);
        rst_n = r; ch_en = en; cfg_we = we; cfg_ch = ch; cfg_div = dv; sync = sy;
        @(posedge clk);
        #1;
        chk({nm, ".clkout"}, clkout, ec);
        chk({nm, ".tick"}, tick, et);
        chk({nm, ".pending"}, pending, ep);
        cfg_we = 1'b0; sync = 1'b0;
    endtask

    // Remaining cycles k=1..n-1 of a period on channel c, no writes
    task automatic tail(input int c, input int n, input logic [2:0] en,
                        input logic pnd, input string nm);
        logic [2:0] m;
        m = 3'(1 << c);
        for (int k = 1; k < n; k++)
            cyc(1'b1, en, 1'b0, 2'd0, 8'd0, 1'b0,
                (k < n / 2) ? m : 3'b000, (k == n - 1) ? m : 3'b000,
                pnd ? m : 3'b000, nm);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{1'b0, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[2]  = '{1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000};
        tbl[3]  = '{1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b001, 3'b000};
        tbl[4]  = '{1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000};
        tbl[5]  = '{1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b001, 3'b000};
        tbl[6]  = '{1'b1, 3'b001, 1'b1, 2'd1, 8'd5, 1'b0, 3'b001, 3'b000, 3'b000};
        tbl[7]  = '{1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b001, 3'b000};
        tbl[8]  = '{1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b011, 3'b000, 3'b000};
        tbl[9]  = '{1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b001, 3'b000};
        tbl[10] = '{1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000};
        tbl[11] = '{1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b011, 3'b000};
        tbl[12] = '{1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b011, 3'b000, 3'b000};
        tbl[13] = '{1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b000, 3'b000};
        tbl[14] = '{1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000};

        // Reset, divide-by-2 on ch0, halted write of 5 to ch1, ch1 runs divide-by-5
        for (int i = 0; i < 15; i++)
            cyc(tbl[i].r, tbl[i].en, tbl[i].we, tbl[i].ch, tbl[i].dv, tbl[i].sy,
                tbl[i].ec, tbl[i].et, tbl[i].ep, $sformatf("tbl%0d", i));

        // N=4 on ch0, write 6 mid-period: pending until wrap, then 6-cycle period
        cyc(1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "c_rst");
        cyc(1'b1, 3'b000, 1'b1, 2'd0, 8'd4, 1'b0, 3'b000, 3'b000, 3'b000, "c_ld4");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "c_cnt0");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "c_cnt1");
        cyc(1'b1, 3'b001, 1'b1, 2'd0, 8'd6, 1'b0, 3'b000, 3'b000, 3'b001, "c_wr6");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b001, 3'b001, "c_cnt3");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "c_n6");
        tail(0, 6, 3'b001, 1'b0, "c_p6a");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "c_p6b0");
        tail(0, 6, 3'b001, 1'b0, "c_p6b");

        // ch2: write 3 then 7 in one period; then a write on the exact boundary
        cyc(1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "d_rst");
        cyc(1'b1, 3'b000, 1'b1, 2'd2, 8'd4, 1'b0, 3'b000, 3'b000, 3'b000, "d_ld4");
        cyc(1'b1, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b100, 3'b000, 3'b000, "d_cnt0");
        cyc(1'b1, 3'b100, 1'b1, 2'd2, 8'd3, 1'b0, 3'b100, 3'b000, 3'b100, "d_wr3");
        cyc(1'b1, 3'b100, 1'b1, 2'd2, 8'd7, 1'b0, 3'b000, 3'b000, 3'b100, "d_wr7");
        cyc(1'b1, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b100, 3'b100, "d_cnt3");
        cyc(1'b1, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b100, 3'b000, 3'b000, "d_n7");
        tail(2, 7, 3'b100, 1'b0, "d_p7a");
        cyc(1'b1, 3'b100, 1'b1, 2'd2, 8'd5, 1'b0, 3'b100, 3'b000, 3'b100, "d_bwr5");
        tail(2, 7, 3'b100, 1'b1, "d_p7b");
        cyc(1'b1, 3'b100, 1'b0, 2'd0, 8'd0, 1'b0, 3'b100, 3'b000, 3'b000, "d_n5");
        tail(2, 5, 3'b100, 1'b0, "d_p5");

        // N=3 and N=4 out of phase, sync realigns; pending shadow applied by sync
        cyc(1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "e_rst");
        cyc(1'b1, 3'b000, 1'b1, 2'd0, 8'd3, 1'b0, 3'b000, 3'b000, 3'b000, "e_ld3");
        cyc(1'b1, 3'b000, 1'b1, 2'd1, 8'd4, 1'b0, 3'b000, 3'b000, 3'b000, "e_ld4");
        cyc(1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b000, 3'b000, "e_st1");
        cyc(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b011, 3'b000, 3'b000, "e_st0");
        cyc(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "e_run");
        cyc(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b000, 3'b000, "e_sync");
        cyc(1'b1, 3'b011, 1'b1, 2'd1, 8'd2, 1'b0, 3'b010, 3'b000, 3'b010, "e_wr2");
        cyc(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b1, 3'b011, 3'b000, 3'b000, "e_sync2");
        cyc(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b010, 3'b000, "e_a1");
        cyc(1'b1, 3'b011, 1'b0, 2'd0, 8'd0, 1'b0, 3'b010, 3'b001, 3'b000, "e_a2");

        // Reset mid-period with N=8, invalid channel write, en drop while pending, N=0
        cyc(1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "f_rst");
        cyc(1'b1, 3'b000, 1'b1, 2'd0, 8'd8, 1'b0, 3'b000, 3'b000, 3'b000, "f_ld8");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "f_c0");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "f_c1");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "f_c2");
        cyc(1'b0, 3'b001, 1'b1, 2'd0, 8'd9, 1'b1, 3'b000, 3'b000, 3'b000, "f_midrst");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "f_n2a");
        cyc(1'b1, 3'b001, 1'b1, 2'd3, 8'd9, 1'b0, 3'b000, 3'b001, 3'b000, "f_badch");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "f_n2b");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b001, 3'b000, "f_n2c");
        cyc(1'b1, 3'b001, 1'b1, 2'd0, 8'd5, 1'b0, 3'b001, 3'b000, 3'b001, "f_wr5");
        cyc(1'b1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "f_endrop");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, "f_n5");
        tail(0, 5, 3'b001, 1'b0, "f_p5");
        cyc(1'b1, 3'b001, 1'b1, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b001, "f_wr0");
        tail(0, 5, 3'b001, 1'b1, "f_p5z");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "f_halt0");
        cyc(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, "f_halt1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter DIV_W, default 16, divisor width in bits.
REQ-003 Parameter RESET_DIV, default 2, active divisor of every channel after reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cfg_we  input  1  config write strobe, one write per asserted cycle.
REQ-007 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of write.
REQ-008 cfg_div  input  DIV_W  new divisor N for target channel.
REQ-009 ch_en  input  NUM_CH  per-channel run enable, level.
REQ-010 sync  input  1  phase-align pulse, restarts all running channels.
REQ-011 clkout  output  NUM_CH  registered divided clock per channel.
REQ-012 tick  output  NUM_CH  registered one-cycle clock-enable pulse, once per period.
REQ-013 pending  output  NUM_CH  shadow divisor awaiting application.

Function
REQ-014 Each channel SHALL hold an active divisor N, a shadow divisor, a pending flag and a counter cnt (0..N-1); all outputs SHALL come directly from flops.
REQ-015 A channel SHALL be running when ch_en=1 and N>=1; otherwise it SHALL be halted (cnt=0, clkout=0, tick=0 from the next edge).
REQ-016 Period SHALL be exactly N cycles; with H=floor(N/2), clkout SHALL be high for the first H cycles of a period and low for the remaining N-H.
REQ-017 tick SHALL be high only on the last cycle of each period (N=1: every cycle, clkout constantly 0).
REQ-018 On the edge a halted channel becomes running, cnt<=0 and the first period SHALL start on the following cycle (clkout=1 if H>0).
REQ-019 Boundary edge: edge where a running channel's cnt==N-1 before the edge; cnt SHALL wrap to 0 there.
REQ-020 A write with cfg_ch>=NUM_CH SHALL be ignored.
REQ-021 A write to a halted channel SHALL load N directly at that edge; pending stays 0.
REQ-022 A write to a running channel SHALL load the shadow and set pending at that edge; at the next boundary edge N<=shadow and pending<=0.
REQ-023 A write coinciding with a boundary edge SHALL NOT be applied at that boundary; it waits for the next one.
REQ-024 A write while pending=1 SHALL overwrite the shadow; only the last value is applied.
REQ-025 Writing N=0 to a running channel SHALL halt it at the application boundary.
REQ-026 sync=1 SHALL act as a boundary edge for every running channel: cnt<=0, pending shadow applied, sync overriding normal counting.
REQ-027 If ch_en falls while pending=1, the shadow SHALL be applied at that edge and pending cleared.
REQ-028 Channels SHALL be fully independent except for shared cfg bus and sync.

Reset
REQ-029 With rst_n=0 at an edge: every N<=RESET_DIV, shadow<=RESET_DIV, pending<=0, cnt<=0, clkout<=0, tick<=0.
REQ-030 Reset mid-period SHALL abort the period with no trailing tick; the first period after rst_n rises follows REQ-018.
REQ-031 Reset SHALL take priority over sync, cfg_we and ch_en.

Structure
REQ-032 Shared package clk_div_pkg SHALL hold the divisor type width default, half-period function floor(N/2), and the channel-index width function.
REQ-033 One sub-module clk_div_channel (one channel: counter, shadow, pending, output flops) SHALL be instantiated NUM_CH times; the top decodes cfg_ch.
REQ-034 No negedge logic, no gated or combinational clock paths; clkout is a data signal for enable or forwarding only.

Verification
REQ-035 Reset, ch_en=4'b0001, N=2 -> ch0 clkout 1,0,1,0..., tick on every 2nd cycle; other channels 0.
REQ-036 N=5 running -> clkout high 2, low 3 cycles; tick coincides with 5th cycle each period.
REQ-037 N=4 running, write 6 at cnt=1 -> pending=1 until wrap; next period 6 cycles (high 3); pending=0 thereafter.
REQ-038 Write 3 then 7 before boundary on ch2 -> only 7 applied; write on exact boundary edge -> applied one period later.
REQ-039 Channels at N=3 and N=4 out of phase, sync pulse -> both cnt=0 next cycle, clkout rising together.
REQ-040 rst_n low mid-period with N=8 -> all outputs 0 next cycle, N back to 2; write cfg_ch=NUM_CH -> no state change.
